// File: rtl/load_rs_multi_pkg.sv
// rtl/load_rs_multi_pkg.sv - shared widths, instruction fields, cache FSM states and operand capture
package load_rs_multi_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int RB_INDEX     = 4;
    localparam int RB_SIZE      = 2 ** RB_INDEX;
    localparam int REG_INDEX    = 5;
    localparam int FU_INDEX     = 3;
    localparam int FU_NUM       = 8;
    localparam int OPCODE_WIDTH = 6;
    localparam int MEM_STALL    = 4;

    localparam logic [OPCODE_WIDTH-1:0] INST_LI   = 6'd1;
    localparam logic [OPCODE_WIDTH-1:0] INST_LW   = 6'd2;
    localparam logic [OPCODE_WIDTH-1:0] INST_LWRR = 6'd3;

    // Word layout: opcode[31:26] rs[25:21] rt[20:16] imm[15:0]; LI uses [25:0] as its literal.
    localparam int RS_START  = 25;
    localparam int RT_START  = 20;
    localparam int IMM_START = 15;

    // Tag 0 is never handed out by the ROB, so it doubles as "value present" and "no tag".
    localparam logic [RB_INDEX-1:0] READY = '0;
    localparam logic [RB_INDEX-1:0] NULL  = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_STALL
    } cache_state_e;

    typedef struct packed {
        logic [WORD_SIZE-1:0] v;
        logic [RB_INDEX-1:0]  q;
    } operand_t;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic [RB_INDEX-1:0]  dest;
        operand_t             opj;
        operand_t             opk;
        logic [WORD_SIZE-1:0] result;
    } entry_t;

    function automatic operand_t capture_operand(
        input logic [WORD_SIZE-1:0]         v,
        input logic [RB_INDEX-1:0]          q,
        input logic [WORD_SIZE*RB_SIZE-1:0] cdb_data,
        input logic [RB_SIZE-1:0]           cdb_valid
    );
        operand_t o;
        o.v = v;
        o.q = q;
        if (q != READY && cdb_valid[q]) begin
            o.v = cdb_data[int'(q)*WORD_SIZE +: WORD_SIZE];
            o.q = READY;
        end
        return o;
    endfunction

endpackage

// File: rtl/load_rs_multi_age.sv
// rtl/load_rs_multi_age.sv - allocation-order age matrix granting the oldest requester
module rs_age_matrix #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] alloc_oh,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    // older_q[i][j] set means entry i was allocated before entry j.
    logic [N-1:0] older_q [N];
    logic [N-1:0] older_d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            older_d[i] = older_q[i];
            for (int j = 0; j < N; j++) begin
                if (i == j || alloc_oh[i]) begin
                    older_d[i][j] = 1'b0;
                end else if (alloc_oh[j]) begin
                    older_d[i][j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant = req;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j != i && req[j] && older_q[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule

// File: rtl/load_rs_multi.sv
// rtl/load_rs_multi.sv - multi-entry load reservation station with oldest-first cache issue and broadcast
module load_rs_multi
    import load_rs_multi_pkg::*;
#(
    parameter int ENTRIES          = 4,
    parameter int FU_ID            = 0,
    parameter int MEM_STALL_CYCLES = MEM_STALL
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [FU_INDEX-1:0]          fu,
    input  logic [RB_INDEX-1:0]          RB_index,
    input  logic [WORD_SIZE-1:0]         inst,
    output logic [REG_INDEX-1:0]         reg_numj,
    output logic [REG_INDEX-1:0]         reg_numk,
    input  logic [WORD_SIZE-1:0]         vj,
    input  logic [WORD_SIZE-1:0]         vk,
    input  logic [RB_INDEX-1:0]          qj,
    input  logic [RB_INDEX-1:0]          qk,
    input  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data,
    input  logic [RB_SIZE-1:0]           CDB_data_valid,
    output logic                         busy,
    output logic [WORD_SIZE-1:0]         result,
    output logic                         valid,
    output logic [RB_INDEX-1:0]          dest,
    output logic [WORD_SIZE-1:0]         c_ptr,
    output logic                         c_read_enable,
    input  logic [WORD_SIZE-1:0]         c_out,
    input  logic                         c_hit
);

    localparam int IW    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(MEM_STALL_CYCLES + 2);
    localparam logic [FU_INDEX-1:0] FU_CODE = FU_INDEX'(FU_ID);

    entry_t               ent_q [ENTRIES];
    entry_t               ent_d [ENTRIES];
    cache_state_e         state_q, state_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [IW-1:0]        req_idx_q, req_idx_d;
    logic                 valid_q, valid_d;
    logic [RB_INDEX-1:0]  dest_q, dest_d;
    logic [WORD_SIZE-1:0] result_q, result_d;

    logic [ENTRIES-1:0]      occupied, free_oh, alloc_oh;
    logic [ENTRIES-1:0]      mem_ready, done_mask, cache_grant, bcast_grant;
    logic                    accept, cache_done;
    logic [OPCODE_WIDTH-1:0] opcode;
    entry_t                  new_ent;

    assign reg_numj = inst[RS_START -: REG_INDEX];
    assign reg_numk = inst[RT_START -: REG_INDEX];

    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            occupied[e]  = ent_q[e].valid;
            done_mask[e] = ent_q[e].valid && ent_q[e].done;
            mem_ready[e] = ent_q[e].valid && !ent_q[e].done &&
                           ent_q[e].opj.q == READY && ent_q[e].opk.q == READY;
        end
    end

    // Occupancy comes from registered state only, so a broadcast this cycle cannot open a slot early.
    assign busy     = &occupied;
    assign accept   = (fu == FU_CODE) && !busy;
    assign free_oh  = ~occupied & (occupied + ENTRIES'(1));
    assign alloc_oh = accept ? free_oh : '0;

    always_comb begin
        opcode  = inst[WORD_SIZE-1 -: OPCODE_WIDTH];
        new_ent = '0;
        new_ent.valid = 1'b1;
        new_ent.dest  = RB_index;
        if (opcode == INST_LI) begin
            new_ent.done   = 1'b1;
            new_ent.result = WORD_SIZE'(inst[RS_START:0]);
        end else begin
            new_ent.opj = capture_operand(vj, qj, CDB_data_data, CDB_data_valid);
            if (opcode == INST_LWRR) begin
                new_ent.opk = capture_operand(vk, qk, CDB_data_data, CDB_data_valid);
            end else begin
                new_ent.opk.v = WORD_SIZE'(inst[IMM_START:0]);
                new_ent.opk.q = READY;
            end
        end
    end

    rs_age_matrix #(.N(ENTRIES)) u_cache_age (
        .clk      (clk),
        .reset    (reset),
        .alloc_oh (alloc_oh),
        .req      (mem_ready),
        .grant    (cache_grant)
    );

    rs_age_matrix #(.N(ENTRIES)) u_bcast_age (
        .clk      (clk),
        .reset    (reset),
        .alloc_oh (alloc_oh),
        .req      (done_mask),
        .grant    (bcast_grant)
    );

    always_comb begin
        state_d       = state_q;
        stall_cnt_d   = stall_cnt_q;
        req_idx_d     = req_idx_q;
        c_read_enable = 1'b0;
        c_ptr         = '0;
        cache_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|cache_grant) begin
                    c_read_enable = 1'b1;
                    for (int e = 0; e < ENTRIES; e++) begin
                        if (cache_grant[e]) begin
                            c_ptr     = ent_q[e].opj.v + ent_q[e].opk.v;
                            req_idx_d = IW'(e);
                        end
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (c_hit) begin
                    cache_done = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    stall_cnt_d = CNT_W'(MEM_STALL_CYCLES);
                    state_d     = ST_STALL;
                end
            end
            ST_STALL: begin
                if (stall_cnt_q <= CNT_W'(1)) begin
                    cache_done  = 1'b1;
                    stall_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_d  = |bcast_grant;
        dest_d   = NULL;
        result_d = result_q;
        for (int e = 0; e < ENTRIES; e++) begin
            if (bcast_grant[e]) begin
                dest_d   = ent_q[e].dest;
                result_d = ent_q[e].result;
            end
        end
    end

    // Free happens before allocate; allocation only ever targets a slot that was empty last cycle.
    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            ent_d[e] = ent_q[e];
            if (ent_q[e].valid) begin
                ent_d[e].opj = capture_operand(ent_q[e].opj.v, ent_q[e].opj.q,
                                               CDB_data_data, CDB_data_valid);
                ent_d[e].opk = capture_operand(ent_q[e].opk.v, ent_q[e].opk.q,
                                               CDB_data_data, CDB_data_valid);
            end
            if (cache_done && req_idx_q == IW'(e)) begin
                ent_d[e].result = c_out;
                ent_d[e].done   = 1'b1;
            end
            if (bcast_grant[e]) begin
                ent_d[e] = '0;
            end
            if (alloc_oh[e]) begin
                ent_d[e] = new_ent;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < ENTRIES; e++) begin
                ent_q[e] <= '0;
            end
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
            req_idx_q   <= '0;
            valid_q     <= 1'b0;
            dest_q      <= NULL;
            result_q    <= '0;
        end else begin
            for (int e = 0; e < ENTRIES; e++) begin
                ent_q[e] <= ent_d[e];
            end
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            req_idx_q   <= req_idx_d;
            valid_q     <= valid_d;
            dest_q      <= dest_d;
            result_q    <= result_d;
        end
    end

    assign valid  = valid_q;
    assign dest   = dest_q;
    assign result = result_q;

endmodule

// File: tb/tb_load_rs_multi.sv
// tb/tb_load_rs_multi.sv - scoreboard bench for load_rs_multi with a simple hit/miss cache responder
module tb_load_rs_multi;
    import load_rs_multi_pkg::*;

    localparam int TB_FU = 0;
    localparam logic [FU_INDEX-1:0] FU_IDLE = 3'd5;

    logic                         clk;
    logic                         reset;
    logic [FU_INDEX-1:0]          fu;
    logic [RB_INDEX-1:0]          RB_index;
    logic [WORD_SIZE-1:0]         inst;
    logic [REG_INDEX-1:0]         reg_numj, reg_numk;
    logic [WORD_SIZE-1:0]         vj, vk;
    logic [RB_INDEX-1:0]          qj, qk;
    logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
    logic [RB_SIZE-1:0]           CDB_data_valid;
    logic                         busy;
    logic [WORD_SIZE-1:0]         result;
    logic                         valid;
    logic [RB_INDEX-1:0]          dest;
    logic [WORD_SIZE-1:0]         c_ptr;
    logic                         c_read_enable;
    logic [WORD_SIZE-1:0]         c_out;
    logic                         c_hit;

    load_rs_multi #(.ENTRIES(4), .FU_ID(TB_FU), .MEM_STALL_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .fu             (fu),
        .RB_index       (RB_index),
        .inst           (inst),
        .reg_numj       (reg_numj),
        .reg_numk       (reg_numk),
        .vj             (vj),
        .vk             (vk),
        .qj             (qj),
        .qk             (qk),
        .CDB_data_data  (CDB_data_data),
        .CDB_data_valid (CDB_data_valid),
        .busy           (busy),
        .result         (result),
        .valid          (valid),
        .dest           (dest),
        .c_ptr          (c_ptr),
        .c_read_enable  (c_read_enable),
        .c_out          (c_out),
        .c_hit          (c_hit)
    );

    typedef struct {
        logic [RB_INDEX-1:0]  dest;
        logic [WORD_SIZE-1:0] result;
    } bc_t;

    bc_t               exp_bc [$];
    logic [31:0]       exp_req [$];
    bc_t               mon_bc;
    logic [31:0]       mon_addr;
    int                n_checks = 0;
    int                n_fail = 0;
    int                cyc = 0;
    int                last_bc_cyc = 0;
    int                last_req_cyc = 0;
    logic              mon_en = 1'b0;
    logic              cache_hit_mode = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] cache_val(input logic [31:0] addr);
        return (addr == 32'd104) ? 32'd55 : addr + 32'd7;
    endfunction

    task automatic push_bc(input logic [RB_INDEX-1:0] d, input logic [31:0] r);
        bc_t b;
        b.dest   = d;
        b.result = r;
        exp_bc.push_back(b);
    endtask

    // Monitor: pops expected broadcasts/requests whenever the DUT presents one.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (valid) begin
                last_bc_cyc = cyc;
                if (exp_bc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_broadcast: got dest %0d result %0d, expected none", dest, result);
                end else begin
                    mon_bc = exp_bc.pop_front();
                    check("bc_dest", 32'(dest), 32'(mon_bc.dest));
                    check("bc_result", result, mon_bc.result);
                end
            end else begin
                check("idle_dest_null", 32'(dest), 32'(NULL));
            end
            if (c_read_enable) begin
                last_req_cyc = cyc;
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_request: got c_ptr %0d, expected none", c_ptr);
                end else begin
                    mon_addr = exp_req.pop_front();
                    check("req_c_ptr", c_ptr, mon_addr);
                end
            end
        end
    end

    // Cache: answers in the cycle after the request, holds c_out until the next one.
    initial begin
        logic [31:0] addr;
        c_hit = 1'b0;
        c_out = '0;
        forever begin
            @(negedge clk);
            if (c_read_enable) begin
                addr = c_ptr;
                @(posedge clk);
                #1;
                c_hit = cache_hit_mode;
                c_out = cache_val(addr);
                @(posedge clk);
                #1;
                c_hit = 1'b0;
            end
        end
    end

    task automatic dispatch(input logic [RB_INDEX-1:0] tag, input logic [31:0] ins,
                            input logic [31:0] vj_i, input logic [RB_INDEX-1:0] qj_i,
                            input logic [31:0] vk_i, input logic [RB_INDEX-1:0] qk_i,
                            output int dcyc);
        dcyc     = cyc;
        fu       = FU_INDEX'(TB_FU);
        RB_index = tag;
        inst     = ins;
        vj       = vj_i;
        qj       = qj_i;
        vk       = vk_i;
        qk       = qk_i;
        @(posedge clk);
        #1;
        fu = FU_IDLE;
    endtask

    task automatic cdb_set(input logic [RB_INDEX-1:0] tag, input logic [31:0] data);
        CDB_data_data[int'(tag)*WORD_SIZE +: WORD_SIZE] = data;
        CDB_data_valid[tag] = 1'b1;
    endtask

    task automatic cdb_clear();
        CDB_data_valid = '0;
        CDB_data_data  = '0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_bc.size() != 0 || exp_req.size() != 0) && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_drained"}, 32'(exp_bc.size() + exp_req.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        int k;
        reset    = 1'b1;
        fu       = FU_IDLE;
        RB_index = '0;
        inst     = '0;
        vj       = '0;
        vk       = '0;
        qj       = '0;
        qk       = '0;
        cdb_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_dest", 32'(dest), 32'(NULL));
        check("rst_result", result, 32'd0);
        check("rst_c_read_enable", 32'(c_read_enable), 32'd0);
        check("rst_c_ptr", c_ptr, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // LI r1,#7 with tag 3
        push_bc(4'd3, 32'd7);
        dispatch(4'd3, {INST_LI, 26'd7}, 32'd0, READY, 32'd0, READY, d);
        check("li_busy", 32'(busy), 32'd0);
        wait_drain("li");
        check("li_latency", 32'(last_bc_cyc - d), 32'd2);

        // LW hit: vj=100 imm=4 -> addr 104 -> data 55
        cache_hit_mode = 1'b1;
        inst = mk(INST_LW, 5'd1, 5'd2, 16'd4);
        #1;
        check("reg_numj", 32'(reg_numj), 32'd1);
        check("reg_numk", 32'(reg_numk), 32'd2);
        exp_req.push_back(32'd104);
        push_bc(4'd4, 32'd55);
        dispatch(4'd4, mk(INST_LW, 5'd1, 5'd2, 16'd4), 32'd100, READY, 32'd0, READY, d);
        wait_drain("lw_hit");
        check("lw_req_latency", 32'(last_req_cyc - d), 32'd1);
        check("lw_bc_latency", 32'(last_bc_cyc - last_req_cyc), 32'd3);

        // LWRR miss: qk=5 pending, CDB delivers 8 two cycles later, vj=16 -> addr 24 -> data 31
        cache_hit_mode = 1'b0;
        exp_req.push_back(32'd24);
        push_bc(4'd7, 32'd31);
        dispatch(4'd7, mk(INST_LWRR, 5'd2, 5'd3, 16'd0), 32'd16, READY, 32'd999, 4'd5, d);
        @(posedge clk);
        #1;
        cdb_set(4'd5, 32'd8);
        @(posedge clk);
        #1;
        cdb_clear();
        wait_drain("lwrr_miss");
        check("lwrr_req_latency", 32'(last_req_cyc - d), 32'd3);
        check("lwrr_bc_latency", 32'(last_bc_cyc - last_req_cyc), 32'd7);

        // Dispatch snoop: qj=6 broadcast the same cycle with 40, imm 0
        cache_hit_mode = 1'b1;
        exp_req.push_back(32'd40);
        push_bc(4'd8, 32'd47);
        cdb_set(4'd6, 32'd40);
        dispatch(4'd8, mk(INST_LW, 5'd3, 5'd0, 16'd0), 32'd0, 4'd6, 32'd0, READY, d);
        cdb_clear();
        wait_drain("snoop");
        check("snoop_req_latency", 32'(last_req_cyc - d), 32'd1);

        // Fill all entries waiting on tag 9, try one more, then release tag 9
        for (int i = 0; i < 4; i++) begin
            dispatch(RB_INDEX'(10 + i), mk(INST_LW, 5'd4, 5'd0, 16'(i)), 32'd0, 4'd9, 32'd0, READY, d);
        end
        check("full_busy", 32'(busy), 32'd1);
        dispatch(4'd14, {INST_LI, 26'd99}, 32'd0, READY, 32'd0, READY, d);
        check("full_busy_after_ignored", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back(32'd1000 + 32'(i));
            push_bc(RB_INDEX'(10 + i), 32'd1007 + 32'(i));
        end
        cdb_set(4'd9, 32'd1000);
        @(posedge clk);
        #1;
        cdb_clear();
        k = 0;
        while (!valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("full_first_bc_seen", 32'(valid), 32'd1);
        check("full_busy_drops", 32'(busy), 32'd0);
        wait_drain("full");

        // Reset while the oldest of three loads sits in the miss stall
        cache_hit_mode = 1'b0;
        exp_req.push_back(32'd200);
        dispatch(4'd1, mk(INST_LW, 5'd1, 5'd0, 16'd0), 32'd200, READY, 32'd0, READY, d);
        dispatch(4'd2, mk(INST_LW, 5'd1, 5'd0, 16'd0), 32'd300, READY, 32'd0, READY, d);
        dispatch(4'd3, mk(INST_LW, 5'd1, 5'd0, 16'd0), 32'd400, READY, 32'd0, READY, d);
        check("stall_req_seen", 32'(exp_req.size()), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_valid", 32'(valid), 32'd0);
        check("flush_dest", 32'(dest), 32'(NULL));
        check("flush_c_read_enable", 32'(c_read_enable), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("flush_no_stale", 32'(exp_bc.size() + exp_req.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
